// File: rtl/spi_pkg.sv
// ---------------------------------------------------------------------------
// spi_pkg
// Shared definitions for the SPI block's APB register port.
//   - apb_state_e : state encoding of the APB master bridge FSM
//   - ADDR_W_DEF / DATA_W_DEF : default APB address and data widths
//   - REG_* : SPI register map addresses seen by the APB initiator
// ---------------------------------------------------------------------------
package spi_pkg;

   localparam int unsigned ADDR_W_DEF = 3;
   localparam int unsigned DATA_W_DEF = 8;

   // SPI register map; address 4 is unused.
   localparam logic [ADDR_W_DEF-1:0] REG_CR1 = 3'd0;
   localparam logic [ADDR_W_DEF-1:0] REG_CR2 = 3'd1;
   localparam logic [ADDR_W_DEF-1:0] REG_BR  = 3'd2;
   localparam logic [ADDR_W_DEF-1:0] REG_SR  = 3'd3;
   localparam logic [ADDR_W_DEF-1:0] REG_DR  = 3'd5;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETUP  = 2'd1,
      ST_ACCESS = 2'd2,
      ST_RESP   = 2'd3
   } apb_state_e;

endpackage

// File: rtl/apb_timeout_counter.sv
// ---------------------------------------------------------------------------
// apb_timeout_counter
// Counts ACCESS cycles that end without PREADY and flags when the access has
// used up its budget of TIMEOUT cycles.
//   PCLK     in  clock, rising edge
//   PRESETn  in  asynchronous active-low reset
//   clear    in  synchronous clear back to zero (takes priority over enable)
//   enable   in  count one more waiting cycle
//   expired  out current cycle is the last allowed ACCESS cycle
//                (count == TIMEOUT-1); never asserted when TIMEOUT == 0
// ---------------------------------------------------------------------------
module apb_timeout_counter #(
   parameter int unsigned TIMEOUT = 16
) (
   input  logic PCLK,
   input  logic PRESETn,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int unsigned CW = $clog2(TIMEOUT) + 1;
   localparam logic [CW-1:0] LAST = (TIMEOUT == 0) ? '0 : CW'(TIMEOUT - 1);

   logic [CW-1:0] count;

   // The count holds at all-ones instead of wrapping, so a very long stall
   // can never roll back below LAST and hide an expiry.
   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (enable && (count != '1)) begin
         count <= count + CW'(1);
      end
   end

   assign expired = (TIMEOUT != 0) && (count == LAST);

endmodule

// File: rtl/apb_master_bridge.sv
// ---------------------------------------------------------------------------
// apb_master_bridge
// APB initiator for the SPI register slave. Takes one register command at a
// time over a valid/ready channel, runs SETUP then ACCESS until PREADY (or a
// timeout), and hands the result back over a valid/ready response channel.
//   PCLK, PRESETn                  clock / async active-low reset
//   cmd_valid, cmd_ready           command handshake
//   cmd_write, cmd_addr, cmd_wdata command contents
//   rsp_valid, rsp_ready           response handshake
//   rsp_rdata, rsp_err, rsp_timeout response contents
//   PSEL, PENABLE, PWRITE, PADDR, PWDATA  APB request (registered)
//   PRDATA, PREADY, PSLVERR        APB completion from the slave
//   busy                           bridge is not idle
// ---------------------------------------------------------------------------
module apb_master_bridge
   import spi_pkg::*;
#(
   parameter int unsigned ADDR_W  = ADDR_W_DEF,
   parameter int unsigned DATA_W  = DATA_W_DEF,
   parameter int unsigned TIMEOUT = 16
) (
   input  logic              PCLK,
   input  logic              PRESETn,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_write,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [DATA_W-1:0] cmd_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_err,
   output logic              rsp_timeout,
   output logic              PSEL,
   output logic              PENABLE,
   output logic              PWRITE,
   output logic [ADDR_W-1:0] PADDR,
   output logic [DATA_W-1:0] PWDATA,
   input  logic [DATA_W-1:0] PRDATA,
   input  logic              PREADY,
   input  logic              PSLVERR,
   output logic              busy
);

   apb_state_e state;
   logic       tmo_expired;

   // The timeout budget starts fresh in SETUP and only burns cycles in
   // ACCESS where the slave is still holding PREADY low.
   apb_timeout_counter #(
      .TIMEOUT (TIMEOUT)
   ) u_timeout (
      .PCLK    (PCLK),
      .PRESETn (PRESETn),
      .clear   (state == ST_SETUP),
      .enable  ((state == ST_ACCESS) && !PREADY),
      .expired (tmo_expired)
   );

   // The requester may only hand over a command while the bridge is idle, so
   // there is never more than one command in flight.
   assign cmd_ready = (state == ST_IDLE);
   assign busy      = (state != ST_IDLE);

   // Main protocol FSM. Every APB and response output is a register updated
   // on the transition into the state that needs it, which keeps the outputs
   // glitch-free. PADDR/PWDATA/PWRITE are loaded only on accept, so they stay
   // stable through SETUP and ACCESS and simply hold afterwards. In ACCESS,
   // PREADY is tested before the timeout so a completion on the last allowed
   // cycle is reported as a normal completion.
   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         state       <= ST_IDLE;
         PSEL        <= 1'b0;
         PENABLE     <= 1'b0;
         PWRITE      <= 1'b0;
         PADDR       <= '0;
         PWDATA      <= '0;
         rsp_valid   <= 1'b0;
         rsp_rdata   <= '0;
         rsp_err     <= 1'b0;
         rsp_timeout <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (cmd_valid) begin
                  PWRITE <= cmd_write;
                  PADDR  <= cmd_addr;
                  PWDATA <= cmd_wdata;
                  PSEL   <= 1'b1;
                  state  <= ST_SETUP;
               end
            end
            ST_SETUP: begin
               PENABLE <= 1'b1;
               state   <= ST_ACCESS;
            end
            ST_ACCESS: begin
               if (PREADY) begin
                  rsp_rdata   <= PWRITE ? '0 : PRDATA;
                  rsp_err     <= PSLVERR;
                  rsp_timeout <= 1'b0;
                  rsp_valid   <= 1'b1;
                  PSEL        <= 1'b0;
                  PENABLE     <= 1'b0;
                  state       <= ST_RESP;
               end else if (tmo_expired) begin
                  rsp_rdata   <= '0;
                  rsp_err     <= 1'b1;
                  rsp_timeout <= 1'b1;
                  rsp_valid   <= 1'b1;
                  PSEL        <= 1'b0;
                  PENABLE     <= 1'b0;
                  state       <= ST_RESP;
               end
            end
            ST_RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  state     <= ST_IDLE;
               end
            end
            default: begin
               PSEL    <= 1'b0;
               PENABLE <= 1'b0;
               state   <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_apb_master_bridge.sv
// ---------------------------------------------------------------------------
// tb_apb_master_bridge
// Directed self-checking bench for apb_master_bridge with TIMEOUT=4. The
// bench plays both the requester and the SPI register slave; inputs change
// 1 time unit after a rising edge and outputs are sampled at that point.
// ---------------------------------------------------------------------------
module tb_apb_master_bridge;
   import spi_pkg::*;

   logic       PCLK;
   logic       PRESETn;
   logic       cmd_valid;
   logic       cmd_ready;
   logic       cmd_write;
   logic [2:0] cmd_addr;
   logic [7:0] cmd_wdata;
   logic       rsp_valid;
   logic       rsp_ready;
   logic [7:0] rsp_rdata;
   logic       rsp_err;
   logic       rsp_timeout;
   logic       PSEL;
   logic       PENABLE;
   logic       PWRITE;
   logic [2:0] PADDR;
   logic [7:0] PWDATA;
   logic [7:0] PRDATA;
   logic       PREADY;
   logic       PSLVERR;
   logic       busy;

   int errors = 0;
   int checks = 0;

   apb_master_bridge #(
      .ADDR_W  (3),
      .DATA_W  (8),
      .TIMEOUT (4)
   ) dut (
      .PCLK        (PCLK),
      .PRESETn     (PRESETn),
      .cmd_valid   (cmd_valid),
      .cmd_ready   (cmd_ready),
      .cmd_write   (cmd_write),
      .cmd_addr    (cmd_addr),
      .cmd_wdata   (cmd_wdata),
      .rsp_valid   (rsp_valid),
      .rsp_ready   (rsp_ready),
      .rsp_rdata   (rsp_rdata),
      .rsp_err     (rsp_err),
      .rsp_timeout (rsp_timeout),
      .PSEL        (PSEL),
      .PENABLE     (PENABLE),
      .PWRITE      (PWRITE),
      .PADDR       (PADDR),
      .PWDATA      (PWDATA),
      .PRDATA      (PRDATA),
      .PREADY      (PREADY),
      .PSLVERR     (PSLVERR),
      .busy        (busy)
   );

   // 10-unit clock
   initial PCLK = 1'b0;
   always #5 PCLK = ~PCLK;

   // Hard stop in case something stalls the sequence
   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic tick();
      @(posedge PCLK);
      #1;
   endtask

   // Requester issues a command; caller then ticks once to have it accepted
   task automatic issue(input logic wr, input logic [2:0] addr, input logic [7:0] wd);
      cmd_valid = 1'b1;
      cmd_write = wr;
      cmd_addr  = addr;
      cmd_wdata = wd;
   endtask

   // Take the pending response and return to IDLE
   task automatic take_response();
      PREADY    = 1'b0;
      PSLVERR   = 1'b0;
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
   endtask

   task automatic test_reset();
      PRESETn   = 1'b0;
      cmd_valid = 1'b0;
      cmd_write = 1'b0;
      cmd_addr  = '0;
      cmd_wdata = '0;
      rsp_ready = 1'b0;
      PRDATA    = '0;
      PREADY    = 1'b0;
      PSLVERR   = 1'b0;
      #2;
      checks++;
      if ({PSEL, PENABLE, PWRITE, rsp_valid, rsp_err, rsp_timeout, busy} !== 7'b0) begin
         errors++;
         $display("[TB] FAIL reset_ctrl: got %b expected 0000000", {PSEL, PENABLE, PWRITE, rsp_valid, rsp_err, rsp_timeout, busy});
      end
      checks++;
      if ({PADDR, PWDATA, rsp_rdata} !== 19'h0) begin
         errors++;
         $display("[TB] FAIL reset_data: got %h expected 0", {PADDR, PWDATA, rsp_rdata});
      end
      checks++;
      if (cmd_ready !== 1'b1) begin
         errors++;
         $display("[TB] FAIL reset_cmd_ready: got %b expected 1", cmd_ready);
      end
      repeat (2) @(posedge PCLK);
      #4 PRESETn = 1'b1;
      tick();
      checks++;
      if ({cmd_ready, busy, PSEL} !== 3'b100) begin
         errors++;
         $display("[TB] FAIL post_reset_idle: got %b expected 100", {cmd_ready, busy, PSEL});
      end
   endtask

   // Write CR1=0x54, slave completes on the second ACCESS cycle
   task automatic test_write_cr1();
      PRDATA = 8'hFF;
      issue(1'b1, REG_CR1, 8'h54);
      tick();
      cmd_valid = 1'b0;
      cmd_wdata = 8'h00;
      checks++;
      if ({PSEL, PENABLE, cmd_ready, busy} !== 4'b1001) begin
         errors++;
         $display("[TB] FAIL wr_setup_ctrl: got %b expected 1001", {PSEL, PENABLE, cmd_ready, busy});
      end
      checks++;
      if ({PWRITE, PADDR, PWDATA} !== {1'b1, 3'd0, 8'h54}) begin
         errors++;
         $display("[TB] FAIL wr_setup_req: got %h expected %h", {PWRITE, PADDR, PWDATA}, {1'b1, 3'd0, 8'h54});
      end
      tick();
      checks++;
      if ({PSEL, PENABLE, rsp_valid} !== 3'b110) begin
         errors++;
         $display("[TB] FAIL wr_access1: got %b expected 110", {PSEL, PENABLE, rsp_valid});
      end
      tick();
      checks++;
      if ({PSEL, PENABLE, rsp_valid, PWRITE, PADDR, PWDATA} !== {4'b1101, 3'd0, 8'h54}) begin
         errors++;
         $display("[TB] FAIL wr_access2: got %h expected %h", {PSEL, PENABLE, rsp_valid, PWRITE, PADDR, PWDATA}, {4'b1101, 3'd0, 8'h54});
      end
      PREADY = 1'b1;
      tick();
      checks++;
      if ({rsp_valid, rsp_err, rsp_timeout, PSEL, PENABLE, cmd_ready} !== 6'b100000) begin
         errors++;
         $display("[TB] FAIL wr_resp_ctrl: got %b expected 100000", {rsp_valid, rsp_err, rsp_timeout, PSEL, PENABLE, cmd_ready});
      end
      checks++;
      if (rsp_rdata !== 8'h00) begin
         errors++;
         $display("[TB] FAIL wr_resp_rdata: got %h expected 00", rsp_rdata);
      end
      take_response();
      checks++;
      if ({rsp_valid, cmd_ready, busy, PADDR, PWDATA} !== {3'b010, 3'd0, 8'h54}) begin
         errors++;
         $display("[TB] FAIL wr_back_idle: got %h expected %h", {rsp_valid, cmd_ready, busy, PADDR, PWDATA}, {3'b010, 3'd0, 8'h54});
      end
   endtask

   // Read DR, slave returns 0xA5 on the first ACCESS cycle
   task automatic test_read_dr();
      issue(1'b0, REG_DR, 8'h00);
      tick();
      cmd_valid = 1'b0;
      checks++;
      if ({PSEL, PENABLE, PWRITE, PADDR} !== {3'b100, 3'd5}) begin
         errors++;
         $display("[TB] FAIL rd_setup: got %b expected %b", {PSEL, PENABLE, PWRITE, PADDR}, {3'b100, 3'd5});
      end
      tick();
      checks++;
      if ({PSEL, PENABLE, PWRITE} !== 3'b110) begin
         errors++;
         $display("[TB] FAIL rd_access: got %b expected 110", {PSEL, PENABLE, PWRITE});
      end
      PREADY = 1'b1;
      PRDATA = 8'hA5;
      tick();
      checks++;
      if ({rsp_valid, rsp_err, rsp_timeout, PWRITE, rsp_rdata} !== {4'b1000, 8'hA5}) begin
         errors++;
         $display("[TB] FAIL rd_resp: got %h expected %h", {rsp_valid, rsp_err, rsp_timeout, PWRITE, rsp_rdata}, {4'b1000, 8'hA5});
      end
      take_response();
   endtask

   // Write DR with the slave flagging PSLVERR on completion
   task automatic test_slverr();
      issue(1'b1, REG_DR, 8'h3C);
      tick();
      cmd_valid = 1'b0;
      tick();
      PREADY  = 1'b1;
      PSLVERR = 1'b1;
      PRDATA  = 8'h99;
      tick();
      checks++;
      if ({rsp_valid, rsp_err, rsp_timeout, PSEL, rsp_rdata} !== {4'b1100, 8'h00}) begin
         errors++;
         $display("[TB] FAIL slverr_resp: got %h expected %h", {rsp_valid, rsp_err, rsp_timeout, PSEL, rsp_rdata}, {4'b1100, 8'h00});
      end
      take_response();
      checks++;
      if ({rsp_valid, cmd_ready} !== 2'b01) begin
         errors++;
         $display("[TB] FAIL slverr_idle: got %b expected 01", {rsp_valid, cmd_ready});
      end
   endtask

   // Slave never answers: four ACCESS cycles, then a timeout response
   task automatic test_timeout();
      int acc;
      PRDATA = 8'h3C;
      issue(1'b0, REG_BR, 8'h00);
      tick();
      cmd_valid = 1'b0;
      tick();
      acc = 0;
      while (PSEL && PENABLE && (acc < 20)) begin
         acc++;
         tick();
      end
      checks++;
      if (acc !== 4) begin
         errors++;
         $display("[TB] FAIL timeout_access_cycles: got %0d expected 4", acc);
      end
      checks++;
      if ({PSEL, PENABLE, rsp_valid, rsp_err, rsp_timeout, rsp_rdata} !== {5'b00111, 8'h00}) begin
         errors++;
         $display("[TB] FAIL timeout_resp: got %h expected %h", {PSEL, PENABLE, rsp_valid, rsp_err, rsp_timeout, rsp_rdata}, {5'b00111, 8'h00});
      end
      take_response();
   endtask

   // Response held back for 5 cycles while the next command waits
   task automatic test_resp_stall();
      PRDATA = 8'h77;
      issue(1'b0, REG_SR, 8'h00);
      tick();
      cmd_write = 1'b1;
      cmd_addr  = REG_CR2;
      cmd_wdata = 8'h12;
      tick();
      PREADY = 1'b1;
      tick();
      PRDATA  = 8'h00;
      PSLVERR = 1'b1;
      for (int i = 0; i < 5; i++) begin
         checks++;
         if ({cmd_ready, PSEL, PENABLE, rsp_valid, rsp_err, rsp_rdata} !== {5'b00010, 8'h77}) begin
            errors++;
            $display("[TB] FAIL stall_hold[%0d]: got %h expected %h", i, {cmd_ready, PSEL, PENABLE, rsp_valid, rsp_err, rsp_rdata}, {5'b00010, 8'h77});
         end
         tick();
      end
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      PREADY    = 1'b0;
      PSLVERR   = 1'b0;
      checks++;
      if ({PSEL, rsp_valid, cmd_ready} !== 3'b001) begin
         errors++;
         $display("[TB] FAIL stall_gap_idle: got %b expected 001", {PSEL, rsp_valid, cmd_ready});
      end
      tick();
      cmd_valid = 1'b0;
      checks++;
      if ({PSEL, PENABLE, PWRITE, PADDR, PWDATA} !== {3'b101, 3'd1, 8'h12}) begin
         errors++;
         $display("[TB] FAIL stall_next_setup: got %h expected %h", {PSEL, PENABLE, PWRITE, PADDR, PWDATA}, {3'b101, 3'd1, 8'h12});
      end
      tick();
      PREADY = 1'b1;
      tick();
      checks++;
      if ({rsp_valid, rsp_err, rsp_rdata} !== {2'b10, 8'h00}) begin
         errors++;
         $display("[TB] FAIL stall_next_resp: got %h expected %h", {rsp_valid, rsp_err, rsp_rdata}, {2'b10, 8'h00});
      end
      take_response();
   endtask

   // Reset asserted mid-ACCESS, then a clean read of SR
   task automatic test_reset_mid();
      PRDATA = 8'h5A;
      issue(1'b0, REG_CR1, 8'h00);
      tick();
      cmd_valid = 1'b0;
      tick();
      checks++;
      if ({PSEL, PENABLE} !== 2'b11) begin
         errors++;
         $display("[TB] FAIL rstmid_in_access: got %b expected 11", {PSEL, PENABLE});
      end
      #1 PRESETn = 1'b0;
      #1;
      checks++;
      if ({PSEL, PENABLE, rsp_valid, busy, cmd_ready} !== 5'b00001) begin
         errors++;
         $display("[TB] FAIL rstmid_async_drop: got %b expected 00001", {PSEL, PENABLE, rsp_valid, busy, cmd_ready});
      end
      #2 PRESETn = 1'b1;
      tick();
      PRDATA = 8'h81;
      issue(1'b0, REG_SR, 8'h00);
      tick();
      cmd_valid = 1'b0;
      tick();
      PREADY = 1'b1;
      tick();
      checks++;
      if ({rsp_valid, rsp_err, rsp_timeout, rsp_rdata} !== {3'b100, 8'h81}) begin
         errors++;
         $display("[TB] FAIL rstmid_fresh_read: got %h expected %h", {rsp_valid, rsp_err, rsp_timeout, rsp_rdata}, {3'b100, 8'h81});
      end
      take_response();
   endtask

   initial begin
      $display("[TB] apb_master_bridge directed bench start");
      test_reset();
      test_write_cr1();
      test_read_dr();
      test_slverr();
      test_timeout();
      test_resp_stall();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/apb_master_bridge.md
# apb_master_bridge

Initiator side of the SPI block's APB register port. Accepts single-beat register commands from an on-chip requester over a valid/ready channel, runs the APB SETUP/ACCESS protocol against the SPI register slave, waits for PREADY, and returns read data and error status on a valid/ready response channel. A programmable timeout aborts any access that the slave never completes.

## Interface
- ADDR_W, 3, APB address width (SPI register map is 3-bit)
- DATA_W, 8, APB data width
- TIMEOUT, 16, max ACCESS cycles without PREADY before abort; 0 disables timeout
- PCLK  in  1  APB clock; all logic rising-edge
- PRESETn  in  1  reset, asynchronous, active-low
- cmd_valid  in  1  requester has a command
- cmd_ready  out  1  bridge can accept a command
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  ADDR_W  register address
- cmd_wdata  in  DATA_W  write data
- rsp_valid  out  1  response available
- rsp_ready  in  1  requester takes response
- rsp_rdata  out  DATA_W  read data (0 for writes and timeouts)
- rsp_err  out  1  PSLVERR captured, or timeout
- rsp_timeout  out  1  access aborted by timeout
- PSEL, PENABLE, PWRITE  out  1 each  APB control
- PADDR  out  ADDR_W  APB address
- PWDATA  out  DATA_W  APB write data
- PRDATA  in  DATA_W  APB read data
- PREADY, PSLVERR  in  1 each  APB completion / error
- busy  out  1  state != IDLE

## Operation
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE: cmd_ready=1, PSEL=0, PENABLE=0. On cmd_valid && cmd_ready, latch cmd_write/addr/wdata into PWRITE/PADDR/PWDATA, go SETUP.
- SETUP (exactly 1 cycle): PSEL=1, PENABLE=0; clear timeout counter; go ACCESS.
- ACCESS: PSEL=1, PENABLE=1. If PREADY: capture PRDATA (reads only, else 0) into rsp_rdata, PSLVERR into rsp_err, rsp_timeout=0, go RESP. Else increment counter; if TIMEOUT!=0 and counter reaches TIMEOUT-1 with PREADY still low: rsp_rdata=0, rsp_err=1, rsp_timeout=1, go RESP.
- RESP: PSEL=0, PENABLE=0, rsp_valid=1; response fields held stable until rsp_valid && rsp_ready, then IDLE.
- PADDR/PWDATA/PWRITE stable from SETUP through end of ACCESS; hold last values in RESP/IDLE.
- Only one outstanding command; cmd_ready=0 in SETUP, ACCESS, RESP.
- Timeout counter width = clog2(TIMEOUT)+1; saturates, never wraps.
- PREADY and timeout in same cycle: PREADY wins (normal completion).
- PREADY/PSLVERR ignored outside ACCESS.

## Timing
- Reset (async): state IDLE; PSEL, PENABLE, PWRITE, PADDR, PWDATA, rsp_valid, rsp_rdata, rsp_err, rsp_timeout, busy all 0; cmd_ready=1 (combinational from IDLE; requester must not issue during reset).
- Reset mid-transfer: PSEL/PENABLE drop immediately; pending command and response discarded.
- Cycle n accept -> n+1 SETUP -> n+2 first ACCESS. PREADY in first ACCESS gives rsp_valid at n+3. The SPI register slave asserts PREADY on the second ACCESS cycle, so rsp_valid at n+4.
- With rsp_ready held high, next accept no earlier than 1 cycle after RESP; PSEL deasserted at least 2 cycles between transfers (RESP, IDLE), returning the slave to its idle state.
- All outputs registered except cmd_ready and busy.

## Structure
- Shared package spi_pkg: FSM state encoding, SPI register addresses (CR1=0, CR2=1, BR=2, SR=3, DR=5), DATA_W/ADDR_W defaults.
- One sub-module: apb_timeout_counter (clear, enable, TIMEOUT parameter, expired output).

## Test plan
- Write CR1=0x54 with PREADY on 2nd ACCESS cycle -> PSEL/PENABLE sequence 10,11,11; rsp_valid at n+4; rsp_err=0, rsp_rdata=0x00.
- Read DR with PRDATA=0xA5, PREADY first ACCESS cycle -> rsp_rdata=0xA5 at n+3, PWRITE=0 throughout.
- Write DR while PSLVERR=1 at PREADY -> rsp_err=1, rsp_timeout=0, transfer still completes.
- TIMEOUT=4, PREADY never high -> exactly 4 ACCESS cycles, then PSEL=0, rsp_err=1, rsp_timeout=1, rsp_rdata=0.
- rsp_ready held low 5 cycles with cmd_valid high -> cmd_ready=0, response stable, no new SETUP until response taken.
- PRESETn low during ACCESS -> PSEL/PENABLE/rsp_valid 0 same cycle; after release, fresh read of SR completes normally.
